// File: rtl/result_uart_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_uart_tx_if : run-result bundle between multiplier top and UART tx  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface result_uart_tx_if;
  logic        done_n;
  logic [31:0] result;
  logic [9:0]  clkcount;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  modport master (
    output done_n, result, clkcount,
    input  tx, busy, frame_done, overrun
  );

  modport slave (
    input  done_n, result, clkcount,
    output tx, busy, frame_done, overrun
  );
endinterface
`default_nettype wire

// File: rtl/result_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | result_uart_tx : snapshots result/clkcount on done_n fall, sends 8N1 frame|
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module result_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  wire             clk,
  input  wire             rstn,
  result_uart_tx_if.slave bus
);

  localparam int            c_CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_CW-1:0] c_BIT_LAST = c_CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic [1:0]      r_state;
  logic [c_CW-1:0] r_bit_cnt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      r_byte_idx;
  logic [31:0]     r_res_s;
  logic [9:0]      r_cnt_s;
  logic            r_done_q;
  logic            r_armed;
  logic            r_frame_done;
  logic            r_overrun;

  logic            w_trig;
  logic            w_bit_end;
  logic [7:0]      w_chk;
  logic [7:0]      w_byte;
  logic            w_tx;

  // r_armed masks the first post-reset cycle so a done_n already low is not an edge
  assign w_trig    = r_armed & r_done_q & ~bus.done_n;
  assign w_bit_end = (r_bit_cnt == c_BIT_LAST);
  assign w_chk     = r_res_s[31:24] ^ r_res_s[23:16] ^ r_res_s[15:8] ^ r_res_s[7:0]
                   ^ {6'b0, r_cnt_s[9:8]} ^ r_cnt_s[7:0];

  always_comb begin
    w_byte = SYNC_BYTE;
    case (r_byte_idx)
      3'd0:    w_byte = SYNC_BYTE;
      3'd1:    w_byte = r_res_s[31:24];
      3'd2:    w_byte = r_res_s[23:16];
      3'd3:    w_byte = r_res_s[15:8];
      3'd4:    w_byte = r_res_s[7:0];
      3'd5:    w_byte = {6'b0, r_cnt_s[9:8]};
      3'd6:    w_byte = r_cnt_s[7:0];
      default: w_byte = w_chk;
    endcase
  end

  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      c_START: w_tx = 1'b0;
      c_DATA:  w_tx = w_byte[r_bit_idx];
      default: w_tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= c_IDLE;
      r_bit_cnt    <= '0;
      r_bit_idx    <= '0;
      r_byte_idx   <= '0;
      r_res_s      <= '0;
      r_cnt_s      <= '0;
      r_done_q     <= 1'b1;
      r_armed      <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_done_q     <= bus.done_n;
      r_armed      <= 1'b1;
      r_frame_done <= 1'b0;
      if (w_trig && (r_state != c_IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        c_IDLE: begin
          if (w_trig) begin
            r_state    <= c_START;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_res_s    <= bus.result;
            r_cnt_s    <= bus.clkcount;
          end
        end
        c_START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_state   <= c_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + c_CW'(1);
          end
        end
        c_DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= '0;
              r_state   <= c_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + c_CW'(1);
          end
        end
        c_STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_byte_idx == 3'd7) begin
              r_byte_idx   <= '0;
              r_state      <= c_IDLE;
              r_frame_done <= 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
              r_state    <= c_START;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + c_CW'(1);
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.tx         = w_tx;
  assign bus.busy       = (r_state != c_IDLE);
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_result_uart_tx : scoreboard bench, serial decoder checks every byte    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_result_uart_tx;
  localparam int c_CPB = 4;

  logic clk;
  logic rstn;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  int run_len  = 0;
  int last_run = 0;
  int fd_cnt   = 0;
  int busy_tot = 0;

  result_uart_tx_if bus ();

  result_uart_tx #(
    .CLKS_PER_BIT (c_CPB),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [31:0] r, input logic [9:0] c);
    logic [7:0] f [8];
    f[0] = 8'hA5;
    f[1] = r[31:24];
    f[2] = r[23:16];
    f[3] = r[15:8];
    f[4] = r[7:0];
    f[5] = {6'b0, c[9:8]};
    f[6] = c[7:0];
    f[7] = f[1] ^ f[2] ^ f[3] ^ f[4] ^ f[5] ^ f[6];
    for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
  endtask

  task automatic wait_fd(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.frame_done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check(tag, (n < 1000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  always @(negedge clk) begin
    if (bus.busy === 1'b1) begin
      run_len++;
      busy_tot++;
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (bus.frame_done === 1'b1) fd_cnt++;
  end

  // Serial decoder: samples mid-bit on falling clock edges
  initial begin
    logic [7:0] b;
    logic [7:0] e;
    bit         bad;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && bus.tx === 1'b0) begin
        bad = 1'b0;
        b   = '0;
        repeat (2) @(negedge clk);
        if (rstn !== 1'b1) bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (c_CPB) @(negedge clk);
          b[i] = bus.tx;
          if (rstn !== 1'b1) bad = 1'b1;
        end
        repeat (c_CPB) @(negedge clk);
        if (rstn !== 1'b1) bad = 1'b1;
        if (!bad) begin
          check("stop_bit", {31'd0, bus.tx}, 32'd1);
          check("byte_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("frame_byte", {24'd0, b}, {24'd0, e});
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int fd0;
    int bt0;

    rstn         = 1'b0;
    bus.done_n   = 1'b1;
    bus.result   = '0;
    bus.clkcount = '0;
    repeat (3) @(negedge clk);
    check("rst_tx",      {31'd0, bus.tx},         32'd1);
    check("rst_busy",    {31'd0, bus.busy},       32'd0);
    check("rst_fd",      {31'd0, bus.frame_done}, 32'd0);
    check("rst_overrun", {31'd0, bus.overrun},    32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame
    bus.result   = 32'h12345678;
    bus.clkcount = 10'h3FF;
    push_frame(32'h12345678, 10'h3FF);
    bus.done_n = 1'b0;
    wait_fd("basic_fd");
    #1;
    check("basic_busy_len", last_run, 80 * c_CPB);
    check("basic_fd_cnt",   fd_cnt, 1);
    check("basic_fd_busy",  {31'd0, bus.busy}, 32'd0);
    check("basic_tx_idle",  {31'd0, bus.tx},   32'd1);
    check("basic_q_empty",  exp_q.size(), 0);
    @(negedge clk);
    check("basic_fd_pulse", {31'd0, bus.frame_done}, 32'd0);
    check("basic_overrun",  {31'd0, bus.overrun},    32'd0);

    // Snapshot isolation
    bus.done_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.result   = 32'h000000FF;
    bus.clkcount = 10'h155;
    push_frame(32'h000000FF, 10'h155);
    bus.done_n = 1'b0;
    repeat (6) @(negedge clk);
    bus.result   = 32'hDEADBEEF;
    bus.clkcount = 10'h0AA;
    wait_fd("snap_fd");
    #1;
    check("snap_busy_len", last_run, 80 * c_CPB);
    check("snap_q_empty",  exp_q.size(), 0);

    // Overrun
    bus.done_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.result   = 32'hA1B2C3D4;
    bus.clkcount = 10'h02A;
    push_frame(32'hA1B2C3D4, 10'h02A);
    bus.done_n = 1'b0;
    repeat (100) @(negedge clk);
    bus.done_n = 1'b1;
    @(negedge clk);
    bus.done_n = 1'b0;
    bus.result = 32'h99999999;
    check("ovr_before", {31'd0, bus.overrun}, 32'd0);
    @(negedge clk);
    check("ovr_set", {31'd0, bus.overrun}, 32'd1);
    wait_fd("ovr_fd");
    #1;
    check("ovr_busy_len", last_run, 80 * c_CPB);
    fd0 = fd_cnt;
    repeat (200) @(negedge clk);
    check("ovr_no_second", fd_cnt - fd0, 0);
    check("ovr_sticky",    {31'd0, bus.overrun}, 32'd1);
    check("ovr_q_empty",   exp_q.size(), 0);

    rstn       = 1'b0;
    bus.done_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst2_overrun", {31'd0, bus.overrun}, 32'd0);
    rstn = 1'b1;
    repeat (3) @(negedge clk);

    // Back-to-back
    bus.result   = 32'h11223344;
    bus.clkcount = 10'h001;
    push_frame(32'h11223344, 10'h001);
    bus.done_n = 1'b0;
    repeat (10) @(negedge clk);
    bus.done_n = 1'b1;
    wait_fd("b2b_fd1");
    check("b2b_fd_busy", {31'd0, bus.busy}, 32'd0);
    bus.result   = 32'hCAFEF00D;
    bus.clkcount = 10'h2C3;
    push_frame(32'hCAFEF00D, 10'h2C3);
    bus.done_n = 1'b0;
    #1;
    check("b2b_len1", last_run, 80 * c_CPB);
    @(negedge clk);
    check("b2b_nogap_busy", {31'd0, bus.busy}, 32'd1);
    check("b2b_nogap_tx",   {31'd0, bus.tx},   32'd0);
    check("b2b_overrun0",   {31'd0, bus.overrun}, 32'd0);
    wait_fd("b2b_fd2");
    #1;
    check("b2b_len2",      last_run, 80 * c_CPB);
    check("b2b_overrun1",  {31'd0, bus.overrun}, 32'd0);
    check("b2b_q_empty",   exp_q.size(), 0);

    // Reset mid-frame
    bus.done_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.result   = 32'h55AA55AA;
    bus.clkcount = 10'h100;
    push_frame(32'h55AA55AA, 10'h100);
    bus.done_n = 1'b0;
    repeat (150) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("rstmid_tx",   {31'd0, bus.tx},   32'd1);
    check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    bt0 = busy_tot;
    fd0 = fd_cnt;
    repeat (500) @(negedge clk);
    check("rstmid_no_busy", busy_tot - bt0, 0);
    check("rstmid_no_fd",   fd_cnt - fd0, 0);

    // Level hold
    bus.done_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.result   = 32'hFFFFFFFF;
    bus.clkcount = 10'h000;
    push_frame(32'hFFFFFFFF, 10'h000);
    fd0 = fd_cnt;
    bus.done_n = 1'b0;
    repeat (1000) @(negedge clk);
    check("hold_one_frame", fd_cnt - fd0, 1);
    check("hold_busy_len",  last_run, 80 * c_CPB);
    check("hold_idle",      {31'd0, bus.busy}, 32'd0);
    check("final_q_empty",  exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Downstream consumer of the matrix-multiplier top level.
- Waits for the multiply run to finish, which is signalled by a falling edge on the active-low done flag.
- At that edge it snapshots the 32-bit accumulated result and the 10-bit cycle count.
- It then sends both to a host as one fixed 8-byte UART frame (8N1). This gives a readout path beside the 7-segment display.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range >= 2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- done_n  input  1  run-complete flag from the A-address counter; high while computing, low when done.
- result  input  32  accumulated dot-product result.
- clkcount  input  10  cycle count of the run.
- tx  output  1  UART serial output; idle level 1.
- busy  output  1  high while a frame is being shifted out.
- frame_done  output  1  one-cycle pulse when a frame completes.
- overrun  output  1  sticky; set when a completion edge arrives while busy.

Behaviour:
- Reset (async, rstn=0) values:
  - tx=1, busy=0, frame_done=0, overrun=0.
  - FSM=IDLE, bit and byte counters=0.
  - done_q (registered done_n)=1.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously). The frame is abandoned and is never resumed.
- Trigger: trig = done_q & ~done_n, evaluated every cycle, with done_q <= done_n.
  - done_n held low does not retrigger.
  - done_n already low when reset releases does not trigger.
- Trigger accepted in IDLE at cycle T:
  - The rising edge ending T loads snapshot registers res_s <= result and cnt_s <= clkcount.
  - busy=1 and tx=0 (start bit) from cycle T+1.
  - Input changes after T do not affect the frame.
- Frame content, in order:
  - B0=SYNC_BYTE.
  - B1..B4 = res_s[31:24], [23:16], [15:8], [7:0].
  - B5 = {6'b0, cnt_s[9:8]}, B6 = cnt_s[7:0].
  - B7 = B1^B2^B3^B4^B5^B6.
- Byte format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles. There is no idle gap between bytes.
- FSM states and transitions:
  - IDLE -> START on trig.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> STOP after 8 bits.
  - STOP -> START when byte index < 7 (index is incremented).
  - STOP -> IDLE when byte index = 7.
- Timing:
  - busy stays high for exactly 80*CLKS_PER_BIT cycles.
  - frame_done pulses high for 1 cycle in the first IDLE cycle after the last stop bit; busy=0 in that cycle.
- Trigger in the frame_done cycle: accepted as a new frame (FSM is IDLE); overrun is not set.
- Trigger while busy:
  - Ignored for the frame; no snapshot is taken and the current frame continues unchanged.
  - overrun <= 1 and stays set until reset.
- Bit counter width is $clog2(CLKS_PER_BIT). Counters wrap to 0 at each bit and byte boundary, with no residual offset between bits.

Test Plan (CLKS_PER_BIT=4):
- Basic frame: result=32'h12345678, clkcount=10'h3FF, drop done_n -> decoded bytes A5 12 34 56 78 03 FF F4; busy high for exactly 320 cycles; one frame_done pulse; tx=1 afterwards.
- Snapshot: start the frame with result=32'h0000_00FF, then change result to 32'hDEADBEEF at cycle T+5 -> frame carries 00 00 00 FF; checksum consistent with the snapshot values.
- Overrun: pulse done_n high then low at cycle 100 of a frame -> frame unchanged; overrun=1 from the next cycle and stays set; no second frame.
- Back-to-back: drive a new falling edge exactly in the frame_done cycle -> second frame starts with no gap; overrun stays 0.
- Reset mid-frame: assert rstn=0 at cycle 150 -> tx=1, busy=0 immediately. Release reset with done_n low -> no frame.
- Level hold: done_n held low for 1000 cycles after one edge -> exactly one frame is sent.
